pzcorebus_request_arbiter: RTL

PZCOREBUS_REQUEST_ARBITER -- requirements
Module: pzcorebus_request_arbiter

---
 rtl/pzcorebus_request_arbiter.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/pzcorebus_request_arbiter.sv
// rtl/pzcorebus_request_arbiter.sv - round-robin command arbiter with in-order write-data routing
module pzcorebus_request_arbiter #(
  parameter int REQUESTERS    = 2,
  parameter int COMMAND_WIDTH = 64,
  parameter int DATA_WIDTH    = 128,
  parameter int ORDER_DEPTH   = 4
) (
  input  logic                                i_clk,
  input  logic                                i_rst,
  input  logic [REQUESTERS-1:0]               i_mcmd_valid,
  output logic [REQUESTERS-1:0]               o_scmd_accept,
  input  logic [REQUESTERS*COMMAND_WIDTH-1:0] i_mcmd,
  input  logic [REQUESTERS-1:0]               i_mcmd_with_data,
  input  logic [REQUESTERS-1:0]               i_mdata_valid,
  output logic [REQUESTERS-1:0]               o_sdata_accept,
  input  logic [REQUESTERS*DATA_WIDTH-1:0]    i_mdata,
  input  logic [REQUESTERS-1:0]               i_mdata_last,
  output logic                                o_mcmd_valid,
  input  logic                                i_scmd_accept,
  output logic [COMMAND_WIDTH-1:0]            o_mcmd,
  output logic                                o_mcmd_with_data,
  output logic                                o_mdata_valid,
  input  logic                                i_sdata_accept,
  output logic [DATA_WIDTH-1:0]               o_mdata,
  output logic                                o_mdata_last,
  output logic                                o_order_full
);

  localparam int IW   = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;
  localparam int PW   = (ORDER_DEPTH > 1) ? $clog2(ORDER_DEPTH) : 1;
  localparam int CNTW = $clog2(ORDER_DEPTH + 1);

  logic [IW-1:0]   prio_q, prio_d;
  logic            lock_q, lock_d;
  logic [IW-1:0]   lock_idx_q, lock_idx_d;
  logic [IW-1:0]   order_q [ORDER_DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0] count_q, count_d;

  logic                  order_full;
  logic                  order_empty;
  logic [REQUESTERS-1:0] eligible;
  logic                  any_eligible;
  logic [IW-1:0]         winner;
  logic [IW-1:0]         grant;
  logic [IW-1:0]         head;
  logic                  cmd_valid;
  logic                  cmd_hs;
  logic                  push;
  logic                  pop;

  // Eligibility looks only at the registered count, so a same-cycle pop never frees a slot early.
  assign order_full  = (count_q == CNTW'(ORDER_DEPTH));
  assign order_empty = (count_q == '0);
  assign eligible    = i_mcmd_valid & ~(i_mcmd_with_data & {REQUESTERS{order_full}});
  assign head        = order_q[rd_ptr_q];

  always_comb begin
    logic [IW:0] sum;
    sum          = '0;
    winner       = prio_q;
    any_eligible = 1'b0;
    // Walk from the farthest slot back to P so the closest eligible requester wins last.
    for (int i = REQUESTERS - 1; i >= 0; i--) begin
      sum = {1'b0, prio_q} + (IW + 1)'(i);
      if (sum >= (IW + 1)'(REQUESTERS)) begin
        sum = sum - (IW + 1)'(REQUESTERS);
      end
      if (eligible[sum[IW-1:0]]) begin
        winner       = sum[IW-1:0];
        any_eligible = 1'b1;
      end
    end
  end

  assign grant     = lock_q ? lock_idx_q : winner;
  assign cmd_valid = lock_q | any_eligible;

  assign o_mcmd_valid     = cmd_valid & ~i_rst;
  assign o_mcmd           = i_mcmd[int'(grant)*COMMAND_WIDTH +: COMMAND_WIDTH];
  assign o_mcmd_with_data = i_mcmd_with_data[grant];
  assign o_mdata_valid    = ~order_empty & i_mdata_valid[head] & ~i_rst;
  assign o_mdata          = i_mdata[int'(head)*DATA_WIDTH +: DATA_WIDTH];
  assign o_mdata_last     = i_mdata_last[head];
  assign o_order_full     = order_full & ~i_rst;

  always_comb begin
    o_scmd_accept  = '0;
    o_sdata_accept = '0;
    if (!i_rst && cmd_valid) begin
      o_scmd_accept[grant] = i_scmd_accept;
    end
    if (!i_rst && !order_empty) begin
      o_sdata_accept[head] = i_sdata_accept;
    end
  end

  assign cmd_hs = o_mcmd_valid & i_scmd_accept;
  assign push   = cmd_hs & o_mcmd_with_data;
  assign pop    = o_mdata_valid & i_sdata_accept & o_mdata_last;

  always_comb begin
    prio_d     = prio_q;
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    if (cmd_hs) begin
      lock_d = 1'b0;
      prio_d = (grant == IW'(REQUESTERS - 1)) ? '0 : grant + 1'b1;
    end else if (o_mcmd_valid) begin
      lock_d     = 1'b1;
      lock_idx_d = grant;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = (wr_ptr_q == PW'(ORDER_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PW'(ORDER_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      prio_q     <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      prio_q     <= prio_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) begin
      order_q[wr_ptr_q] <= grant;
    end
  end

  assert property (@(posedge i_clk) disable iff (i_rst) !(push && order_full && !pop));

endmodule
